// File: rtl/serial_echo_pkg.sv
// Shared frame constants, FSM state types and default timing for serial_echo.
package serial_echo_pkg;

  localparam int DEF_CLK_FREQ  = 50000000;
  localparam int DEF_BAUD_RATE = 115200;

  localparam int DATA_BITS   = 8;
  localparam bit PARITY_EVEN = 1'b1;
  localparam int STOP_BITS   = 1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Parity bit that makes the frame's parity match the configured sense.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ ~PARITY_EVEN;
  endfunction

endpackage

// File: rtl/serial_echo_fifo.sv
// Synchronous first-word fall-through byte FIFO between the UART receiver and
// transmitter. Pushes while full and pops while empty are ignored.
module serial_echo_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer update and storage write; pointers carry one wrap bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/serial_echo.sv
// UART echo: receives 8E1 frames on rx, pushes data+1 into a small FIFO and
// retransmits in the same format on tx.
// Build option SERIAL_ECHO_FLOW_CONTROL_EN: gates TX on rts and drives cts
// from FIFO fullness; otherwise rts is ignored and cts is low outside reset.
// Handshake: FIFO push is accepted when !full, pop when !empty, each on the
// clock edge where the request is high; dout is valid whenever !empty.
module serial_echo
  import serial_echo_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD_RATE  = DEF_BAUD_RATE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx,
  input  logic rts,
  output logic cts
);

  localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int STOP_TICKS = BIT_TICKS * STOP_BITS;
  localparam int CW         = $clog2(STOP_TICKS + 1);
  localparam int IW         = $clog2(DATA_BITS);

  // ---------------------------------------------------------------- sync
  logic rx_m, rx_s, rx_prev;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // ---------------------------------------------------------------- fifo
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_din, fifo_dout;

  serial_echo_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (DATA_BITS)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // ---------------------------------------------------------------- gate
  logic tx_gate;
`ifdef SERIAL_ECHO_FLOW_CONTROL_EN
  assign tx_gate = ~rts;
  assign cts     = ~rst | fifo_full;
`else
  logic unused_rts;
  assign unused_rts = rts;
  assign tx_gate    = 1'b1;
  assign cts        = ~rst;
`endif

  // ---------------------------------------------------------------- rx fsm
  rx_state_t            rx_state, rx_state_n;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [IW-1:0]        rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_par, rx_par_n;

  // RX state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_sh    <= rx_sh_n;
      rx_par   <= rx_par_n;
    end
  end

  // RX next state: mid-bit sampling, push of data+1 at a good stop bit.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_idx_n   = rx_idx;
    rx_sh_n    = rx_sh;
    rx_par_n   = rx_par;
    fifo_push  = 1'b0;
    fifo_din   = rx_sh + 1'b1;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CW'(HALF_TICKS - 1)) begin
          rx_cnt_n   = '0;
          rx_idx_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CW'(BIT_TICKS - 1)) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s, rx_sh[DATA_BITS-1:1]};
          rx_idx_n = rx_idx + 1'b1;
          if (rx_idx == IW'(DATA_BITS - 1)) rx_state_n = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (rx_cnt == CW'(BIT_TICKS - 1)) begin
          rx_cnt_n   = '0;
          rx_par_n   = rx_s;
          rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CW'(BIT_TICKS - 1)) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          if (rx_s && (parity_bit(rx_sh) == rx_par) && !fifo_full) fifo_push = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- tx fsm
  tx_state_t            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [IW-1:0]        tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_par, tx_par_n;
  logic                 tx_line;

  // TX state, datapath and the registered line driver (one cycle behind state).
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      tx       <= tx_line;
    end
  end

  // TX next state: pop on frame start, hold each bit BIT_TICKS clocks.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_idx_n   = tx_idx;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    fifo_pop   = 1'b0;
    tx_line    = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (!fifo_empty && tx_gate) begin
          fifo_pop   = 1'b1;
          tx_sh_n    = fifo_dout;
          tx_par_n   = parity_bit(fifo_dout);
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_cnt == CW'(BIT_TICKS - 1)) begin
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_line = tx_sh[0];
        if (tx_cnt == CW'(BIT_TICKS - 1)) begin
          tx_cnt_n = '0;
          tx_sh_n  = tx_sh >> 1;
          tx_idx_n = tx_idx + 1'b1;
          if (tx_idx == IW'(DATA_BITS - 1)) tx_state_n = TX_PARITY;
        end
      end
      TX_PARITY: begin
        tx_line = tx_par;
        if (tx_cnt == CW'(BIT_TICKS - 1)) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_line = 1'b1;
        if (tx_cnt == CW'(STOP_TICKS - 1)) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
          if (!fifo_empty && tx_gate) begin
            fifo_pop   = 1'b1;
            tx_sh_n    = fifo_dout;
            tx_par_n   = parity_bit(fifo_dout);
            tx_state_n = TX_START;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_echo.sv
// Bench for serial_echo: drives 8E1 frames on rx, decodes tx with an
// independent frame monitor and compares against a queue-based echo model.
`timescale 1ns/1ps
module tb_serial_echo;

  localparam int BIT_TICKS  = 50000000 / 115200;
  localparam int HALF       = BIT_TICKS / 2;
  localparam int FIFO_DEPTH = 4;
`ifdef SERIAL_ECHO_FLOW_CONTROL_EN
  localparam int N_RAND = 1;
`else
  localparam int N_RAND = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic rts = 1'b0;
  logic tx, cts;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] exp_q[$];
  int n_exp       = 0;
  int frames_seen = 0;
  bit mon_busy    = 1'b0;
  bit flow_hold   = 1'b0;

  serial_echo dut (
    .clk(clk),
    .rst(rst),
    .rx (rx),
    .tx (tx),
    .rts(rts),
    .cts(cts)
  );

  // ---------------------------------------------------------- clock
  always #10 clk = ~clk;

  // ---------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // ---------------------------------------------------------- model
  // A good byte becomes byte+1; it is lost only when the buffer is full,
  // which can happen only while the transmitter is held off.
  task automatic model_push(input logic [7:0] d);
    if (flow_hold && exp_q.size() >= FIFO_DEPTH) return;
    exp_q.push_back(d + 8'd1);
    n_exp++;
  endtask

  // ---------------------------------------------------------- driver
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (BIT_TICKS) @(negedge clk);
    end
    rx = 1'b1;
    if (bad_stop) repeat (BIT_TICKS) @(negedge clk);
    if (!bad_par && !bad_stop) model_push(d);
  endtask

  task automatic drain(input string tag);
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || mon_busy) && waited < 12000) begin
      @(negedge clk);
      waited++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------- monitor
  initial begin : monitor
    logic [10:0] bits;
    logic        prev;
    bit          abort;
    logic [7:0]  want;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        mon_busy = 1'b1;
        abort    = 1'b0;
        prev     = 1'b0;
        bits     = '0;
        for (int c = 1; c <= 10 * BIT_TICKS + HALF; c++) begin
          @(negedge clk);
          if (rst !== 1'b1) begin
            abort = 1'b1;
            break;
          end
          if (tx !== prev) begin
            check("bit_edge_align",
                  32'((c % BIT_TICKS) <= 1 || (c % BIT_TICKS) == BIT_TICKS - 1), 32'd1);
            prev = tx;
          end
          if (c % BIT_TICKS == HALF) bits[c / BIT_TICKS] = tx;
        end
        if (!abort) begin
          frames_seen++;
          check("start_bit", 32'(bits[0]), 32'd0);
          check("stop_bit", 32'(bits[10]), 32'd1);
          check("parity_even", 32'(^bits[9:1]), 32'd0);
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("echo_data", 32'(bits[8:1]), 32'(want));
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------- stimulus
  initial begin : stimulus
    int         idle_bad;
    int         waited;
    int         err;
    int         seen_before;
    logic [7:0] d;

    // reset state
    rst = 1'b0;
    rx  = 1'b1;
    rts = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_cts", 32'(cts), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("cts_ready", 32'(cts), 32'd0);

    // long idle
    idle_bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (tx !== 1'b1) idle_bad++;
    end
    check("idle_tx_high", 32'(idle_bad), 32'd0);
    check("idle_cts", 32'(cts), 32'd0);

    // directed frames: normal, wrap, parity error, framing error
    send_frame(8'h53, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    send_frame(8'h53, 1'b1, 1'b0);
    send_frame(8'h53, 1'b0, 1'b1);
    drain("drain_directed");
    check("frames_directed", 32'(frames_seen), 32'(n_exp));

    // five back-to-back frames
`ifdef SERIAL_ECHO_FLOW_CONTROL_EN
    rts         = 1'b1;
    flow_hold   = 1'b1;
    seen_before = n_exp;
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
    check("cts_full", 32'(cts), 32'd1);
    check("held_no_tx", 32'(frames_seen), 32'(seen_before));
    check("held_tx_high", 32'(tx), 32'd1);
    rts       = 1'b0;
    flow_hold = 1'b0;
`else
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
`endif
    drain("drain_burst");
    check("frames_burst", 32'(frames_seen), 32'(n_exp));
    check("cts_after_burst", 32'(cts), 32'd0);

    // random frames with occasional errors
    for (int i = 0; i < N_RAND; i++) begin
      d   = 8'($urandom_range(0, 255));
      err = $urandom_range(0, 3);
      send_frame(d, err == 1, err == 2);
    end
    drain("drain_random");
    check("frames_random", 32'(frames_seen), 32'(n_exp));

    // reset in the middle of a transmitted frame
    send_frame(8'h30, 1'b0, 1'b0);
    waited = 0;
    while (!mon_busy && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("tx_started", 32'(mon_busy), 32'd1);
    repeat (1000) @(negedge clk);
    check("pre_rst_tx_low", 32'(tx), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_tx_next_edge", 32'(tx), 32'd1);
    n_exp -= exp_q.size();
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_cts", 32'(cts), 32'd1);
    rst = 1'b1;
    repeat (6000) @(negedge clk);
    check("no_residual_echo", 32'(frames_seen), 32'(n_exp));
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_cts", 32'(cts), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
